// File: rtl/control_unit.sv
// ============================================================================
// control_unit : multicycle MIPS-subset control FSM with trap sequencing
// Revision     : 1.0
// ============================================================================
`default_nettype none

module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Igual,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       AluSrcA,
  output logic       EPCWrite,
  output logic       IorD,
  output logic       WriteSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ShiftControl,
  output logic [3:0] AluSrcB,
  output logic [3:0] PCSource,
  output logic [1:0] ExcpSel,
  output logic [4:0] State
);

  typedef enum logic [4:0] {
    S_RESET = 5'd0,  S_F0   = 5'd1,  S_F1   = 5'd2,  S_F2   = 5'd3,
    S_DEC   = 5'd4,  S_EX_R = 5'd5,  S_WB_R = 5'd6,  S_SH_LD = 5'd7,
    S_SH_DO = 5'd8,  S_SH_WB = 5'd9, S_JR   = 5'd10, S_EX_I = 5'd11,
    S_WB_I  = 5'd12, S_ADDR = 5'd13, S_LW0  = 5'd14, S_LW1  = 5'd15,
    S_LW2   = 5'd16, S_LW3  = 5'd17, S_SW0  = 5'd18, S_BR   = 5'd19,
    S_J     = 5'd20, S_E0   = 5'd21, S_E1   = 5'd22, S_E2   = 5'd23,
    S_E3    = 5'd24, S_E4   = 5'd25
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] CAUSE_INVALID  = 2'd1;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  state_t     state;
  logic [1:0] cause;
  logic       funct_arith;
  logic       funct_shift;

  assign funct_arith = (FUNCT == FN_ADD) || (FUNCT == FN_SUB) || (FUNCT == FN_AND);
  assign funct_shift = (FUNCT == FN_SLL) || (FUNCT == FN_SRL) || (FUNCT == FN_SRA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RESET;
      cause <= 2'd0;
    end else begin
      case (state)
        S_RESET: state <= S_F0;
        S_F0:    state <= S_F1;
        S_F1:    state <= S_F2;
        S_F2:    state <= S_DEC;
        S_DEC: begin
          if (OPCODE == OP_RTYPE) begin
            if (funct_arith)        state <= S_EX_R;
            else if (funct_shift)   state <= S_SH_LD;
            else if (FUNCT == FN_JR) state <= S_JR;
            else begin
              state <= S_E0;
              cause <= CAUSE_INVALID;
            end
          end else begin
            case (OPCODE)
              OP_ADDI:       state <= S_EX_I;
              OP_LW, OP_SW:  state <= S_ADDR;
              OP_BEQ, OP_BNE: state <= S_BR;
              OP_J:          state <= S_J;
              default: begin
                state <= S_E0;
                cause <= CAUSE_INVALID;
              end
            endcase
          end
        end
        // AND cannot overflow, so only add/sub trap here
        S_EX_R: begin
          if (Overflow && (FUNCT != FN_AND)) begin
            state <= S_E0;
            cause <= CAUSE_OVERFLOW;
          end else begin
            state <= S_WB_R;
          end
        end
        S_EX_I: begin
          if (Overflow) begin
            state <= S_E0;
            cause <= CAUSE_OVERFLOW;
          end else begin
            state <= S_WB_I;
          end
        end
        S_SH_LD: state <= S_SH_DO;
        S_SH_DO: state <= S_SH_WB;
        S_ADDR:  state <= (OPCODE == OP_SW) ? S_SW0 : S_LW0;
        S_LW0:   state <= S_LW1;
        S_LW1:   state <= S_LW2;
        S_LW2:   state <= S_LW3;
        S_E0:    state <= S_E1;
        S_E1:    state <= S_E2;
        S_E2:    state <= S_E3;
        S_E3:    state <= S_E4;
        default: state <= S_F0;
      endcase
    end
  end

  always_comb begin
    PCwrite      = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemToReg     = 1'b0;
    RegDest      = 1'b0;
    AluSrcA      = 1'b0;
    EPCWrite     = 1'b0;
    IorD         = 1'b0;
    WriteSrc     = 1'b0;
    ALUControl   = ALU_PASS;
    ShiftControl = 3'b000;
    AluSrcB      = 4'd0;
    PCSource     = 4'd0;
    ExcpSel      = 2'd0;
    case (state)
      S_F2: begin
        IRWrite    = 1'b1;
        AluSrcB    = 4'd1;
        ALUControl = ALU_ADD;
        PCwrite    = 1'b1;
      end
      S_DEC: begin
        AluSrcB    = 4'd3;
        ALUControl = ALU_ADD;
      end
      S_EX_R: begin
        AluSrcA = 1'b1;
        case (FUNCT)
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      S_SH_LD: ShiftControl = 3'b001;
      S_SH_DO: begin
        case (FUNCT)
          FN_SRL:  ShiftControl = 3'b011;
          FN_SRA:  ShiftControl = 3'b100;
          default: ShiftControl = 3'b010;
        endcase
      end
      S_SH_WB: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
        WriteSrc = 1'b1;
      end
      S_JR: begin
        AluSrcA = 1'b1;
        PCwrite = 1'b1;
      end
      S_EX_I, S_ADDR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 4'd2;
        ALUControl = ALU_ADD;
      end
      S_WB_I: RegWrite = 1'b1;
      S_LW0, S_LW1, S_LW2: begin
        IorD       = 1'b1;
        AluSrcA    = 1'b1;
        AluSrcB    = 4'd2;
        ALUControl = ALU_ADD;
        MemRead    = (state == S_LW2);
      end
      S_LW3: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_SW0: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        AluSrcA    = 1'b1;
        AluSrcB    = 4'd2;
        ALUControl = ALU_ADD;
      end
      S_BR: begin
        AluSrcA    = 1'b1;
        ALUControl = ALU_CMP;
        PCSource   = 4'd1;
        PCwrite    = (OPCODE == OP_BEQ) ? Igual : !Igual;
      end
      S_J: begin
        PCSource = 4'd2;
        PCwrite  = 1'b1;
      end
      S_E0: begin
        AluSrcB    = 4'd1;
        ALUControl = ALU_SUB;
      end
      S_E1, S_E2, S_E3: begin
        IorD     = 1'b1;
        ExcpSel  = cause;
        EPCWrite = (state == S_E1);
        MemRead  = (state == S_E3);
      end
      S_E4: begin
        PCSource = 4'd4;
        PCwrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

`default_nettype wire
